// File: rtl/target_expander.sv
// Expands a compact (nbits-style) difficulty target into a full-width
// unsigned threshold and compares a hash against it, shifting a few bytes per cycle.
module target_expander #(
    parameter int OUT_WIDTH       = 256,
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          nbits_i,
    input  logic [OUT_WIDTH-1:0] hash_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] target_o,
    output logic                 hit_o,
    output logic                 neg_o,
    output logic                 ovf_o
);

    localparam int          OB       = OUT_WIDTH / 8;
    localparam logic [31:0] LIM_ANY  = 32'(OB + 2);
    localparam logic [31:0] LIM_2B   = 32'(OB + 1);
    localparam logic [31:0] LIM_3B   = 32'(OB);
    localparam logic [7:0]  BPC      = 8'(BYTES_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [OUT_WIDTH-1:0]   work_r;
    logic [OUT_WIDTH-1:0]   hash_r;
    logic [7:0]             cnt_r;
    logic                   left_r;
    logic                   neg_r;
    logic                   ovf_r;
    logic                   in_ready_r;

    logic                   accept_s;
    logic [7:0]             exp_s;
    logic [22:0]            mant_s;
    logic [31:0]            exp32_s;
    logic                   mant_nz_s;
    logic                   neg_in_s;
    logic                   ovf_in_s;
    logic [7:0]             cnt_in_s;
    logic [7:0]             step_s;
    logic [10:0]            shamt_s;

    assign in_ready  = in_ready_r;
    assign accept_s  = in_valid & in_ready_r;
    assign exp_s     = nbits_i[31:24];
    assign mant_s    = nbits_i[22:0];
    assign exp32_s   = {24'd0, exp_s};
    assign mant_nz_s = (mant_s != 23'd0);
    assign neg_in_s  = nbits_i[23] & mant_nz_s;
    // Overflow is judged on the significant bytes of M against the output byte count.
    assign ovf_in_s  = mant_nz_s & ((exp32_s > LIM_ANY) |
                                    ((mant_s > 23'h0000FF) & (exp32_s > LIM_2B)) |
                                    ((mant_s > 23'h00FFFF) & (exp32_s > LIM_3B)));
    assign cnt_in_s  = (exp_s >= 8'd3) ? (exp_s - 8'd3) : (8'd3 - exp_s);
    assign step_s    = (cnt_r < BPC) ? cnt_r : BPC;
    assign shamt_s   = {step_s, 3'b000};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (neg_in_s | ovf_in_s | (cnt_in_s == 8'd0)) begin
                        state_s = DONE;
                    end else begin
                        state_s = SHIFT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r <= BPC) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_valid & out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Ready is registered so it stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
        end else begin
            in_ready_r <= (state_s == IDLE);
        end
    end

    // Working register, shift counter and captured operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_r <= {OUT_WIDTH{1'b0}};
            hash_r <= {OUT_WIDTH{1'b0}};
            cnt_r  <= 8'd0;
            left_r <= 1'b0;
            neg_r  <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept_s) begin
            work_r <= OUT_WIDTH'(mant_s);
            hash_r <= hash_i;
            cnt_r  <= cnt_in_s;
            left_r <= (exp_s >= 8'd3);
            neg_r  <= neg_in_s;
            ovf_r  <= ovf_in_s;
        end else if (state_r == SHIFT) begin
            work_r <= left_r ? (work_r << shamt_s) : (work_r >> shamt_s);
            cnt_r  <= cnt_r - step_s;
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
        end
    end

    // Result registers: loaded once on entry to DONE, held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            target_o  <= {OUT_WIDTH{1'b0}};
            hit_o     <= 1'b0;
            neg_o     <= 1'b0;
            ovf_o     <= 1'b0;
        end else if ((state_r == DONE) && !out_valid) begin
            out_valid <= 1'b1;
            target_o  <= (neg_r | ovf_r) ? {OUT_WIDTH{1'b0}} : work_r;
            hit_o     <= (hash_r <= work_r) & ~neg_r & ~ovf_r;
            neg_o     <= neg_r;
            ovf_o     <= ovf_r;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_target_expander.sv
// Scoreboard bench for target_expander: two instances (1 and 4 bytes per cycle),
// directed vectors push expectations, a negedge monitor pops and compares.
module tb_target_expander;

    localparam int W = 256;

    typedef struct {
        logic [W-1:0] target;
        logic         hit;
        logic         neg;
        logic         ovf;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic         hit       [2];
    logic         neg       [2];
    logic         ovf       [2];
    logic [31:0]  nbits     [2];
    logic [W-1:0] hash      [2];
    logic [W-1:0] target    [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic saw_valid = 1'b0;

    logic [W-1:0] t_big;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    target_expander #(.OUT_WIDTH(W), .BYTES_PER_CYCLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .nbits_i(nbits[0]), .hash_i(hash[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .target_o(target[0]), .hit_o(hit[0]),
        .neg_o(neg[0]), .ovf_o(ovf[0]));

    target_expander #(.OUT_WIDTH(W), .BYTES_PER_CYCLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .nbits_i(nbits[1]), .hash_i(hash[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .target_o(target[1]), .hit_o(hit[1]),
        .neg_o(neg[1]), .ovf_o(ovf[1]));

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic send(input int i, input logic [31:0] nb, input logic [W-1:0] h,
                        input logic [W-1:0] t, input logic ht, input logic ng,
                        input logic ov, input int lat, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout inst %0d nbits %h", i, nb);
        end else begin
            nbits[i]    = nb;
            hash[i]     = h;
            in_valid[i] = 1'b1;
            @(posedge clk);
            #1;
            in_valid[i] = 1'b0;
            if (push) begin
                e.target = t;
                e.hit    = ht;
                e.neg    = ng;
                e.ovf    = ov;
                e.due    = cyc + lat;
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q0", W'(q0.size()), {W{1'b0}});
        chk("drain_q1", W'(q1.size()), {W{1'b0}});
    endtask

    // Monitor: compare on each rising out_valid, check stability while stalled.
    initial begin : monitor
        logic         pv [2];
        logic [W-1:0] pt [2];
        logic         ph [2];
        logic         pn [2];
        logic         po [2];
        exp_t         e;
        int           qs;
        pv[0] = 1'b0; pv[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    pv[i] = 1'b0;
                end else begin
                    if (out_valid[i] && !pv[i]) begin
                        qs = (i == 0) ? q0.size() : q1.size();
                        if (qs == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output inst %0d target %h", i, target[i]);
                        end else begin
                            e = (i == 0) ? q0.pop_front() : q1.pop_front();
                            chk($sformatf("target_%0d", i), target[i], e.target);
                            chk($sformatf("hit_%0d", i), W'(hit[i]), W'(e.hit));
                            chk($sformatf("neg_%0d", i), W'(neg[i]), W'(e.neg));
                            chk($sformatf("ovf_%0d", i), W'(ovf[i]), W'(e.ovf));
                            chk($sformatf("latency_%0d", i), W'(cyc), W'(e.due));
                        end
                    end else if (out_valid[i] && pv[i]) begin
                        chk($sformatf("hold_target_%0d", i), target[i], pt[i]);
                        chk($sformatf("hold_flags_%0d", i), W'({hit[i], neg[i], ovf[i]}),
                            W'({ph[i], pn[i], po[i]}));
                    end
                    pv[i] = out_valid[i];
                    pt[i] = target[i];
                    ph[i] = hit[i];
                    pn[i] = neg[i];
                    po[i] = ovf[i];
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            nbits[i]     = 32'd0;
            hash[i]      = {W{1'b0}};
        end
        t_big = 256'h0;
        t_big[223:208] = 16'hFFFF;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", W'(in_ready[0]), {W{1'b0}});
        chk("rst_out_valid", W'(out_valid[0]), {W{1'b0}});
        chk("rst_target", target[0], {W{1'b0}});
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", W'(in_ready[0]), {W{1'b0}});
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", W'(in_ready[0]), {{(W-1){1'b0}}, 1'b1});

        send(0, 32'h1d00ffff, 256'h0, t_big, 1'b1, 1'b0, 1'b0, 27, 1'b1);
        send(0, 32'h1d00ffff, t_big, t_big, 1'b1, 1'b0, 1'b0, 27, 1'b1);
        send(0, 32'h1d00ffff, t_big + 256'd1, t_big, 1'b0, 1'b0, 1'b0, 27, 1'b1);
        send(0, 32'h03123456, 256'h123456, 256'h123456, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        send(0, 32'h01123456, 256'h13, 256'h12, 1'b0, 1'b0, 1'b0, 3, 1'b1);
        send(0, 32'h00123456, 256'h0, 256'h0, 1'b1, 1'b0, 1'b0, 4, 1'b1);
        send(0, 32'h04923456, 256'h0, 256'h0, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        send(0, 32'hff123456, 256'h0, 256'h0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        send(0, 32'hff923456, 256'h0, 256'h0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        send(0, 32'h05000000, 256'h0, 256'h0, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        send(0, 32'h05800000, 256'h0, 256'h0, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        send(0, 32'h220000ff, 256'h1, {8'hFF, 248'h0}, 1'b1, 1'b0, 1'b0, 32, 1'b1);
        send(0, 32'h22000100, 256'h0, 256'h0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        send(0, 32'h2100ffff, 256'h0, {16'hFFFF, 240'h0}, 1'b1, 1'b0, 1'b0, 31, 1'b1);
        send(0, 32'h21010000, 256'h0, 256'h0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        send(0, 32'h23000001, 256'h0, 256'h0, 1'b0, 1'b0, 1'b1, 1, 1'b1);
        send(1, 32'h1d00ffff, 256'h0, t_big, 1'b1, 1'b0, 1'b0, 8, 1'b1);
        send(1, 32'h01123456, 256'h12, 256'h12, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        send(1, 32'h2100ffff, 256'h0, {16'hFFFF, 240'h0}, 1'b1, 1'b0, 1'b0, 9, 1'b1);
        drain();

        // Stall in DONE with ignored input pulses, then release.
        out_ready[0] = 1'b0;
        send(0, 32'h03123456, 256'h5, 256'h123456, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", W'(out_valid[0]), {{(W-1){1'b0}}, 1'b1});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", W'(in_ready[0]), {W{1'b0}});
            in_valid[0] = 1'b1;
            nbits[0]    = 32'h03000007;
        end
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", W'(out_valid[0]), {W{1'b0}});
        chk("release_in_ready", W'(in_ready[0]), {{(W-1){1'b0}}, 1'b1});
        send(0, 32'h01123456, 256'h12, 256'h12, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        drain();

        // Reset mid-SHIFT must discard the operation.
        send(0, 32'h1d00ffff, 256'h0, t_big, 1'b1, 1'b0, 1'b0, 27, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", W'(out_valid[0]), {W{1'b0}});
        chk("midrst_in_ready", W'(in_ready[0]), {W{1'b0}});
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 35; k++) begin
            @(negedge clk);
            if (out_valid[0]) saw_valid = 1'b1;
        end
        chk("midrst_no_output", W'(saw_valid), {W{1'b0}});
        send(0, 32'h03000001, 256'h1, 256'h1, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
